exp_seq_controller: RTL
=======================

// Module: exp_seq_controller
// PURPOSE
//  Control FSM for the exponential datapath wrapper (shift register, ui register, exponential unit, shift combiner).
//  Processes a block of N_ITEMS operands per run. For each item it:
//   - reads the operand address,
//   - loads fracInput/ui,
//   - pre-shifts the operand,
//   - starts the exponential unit and waits for its done,
//   - issues a write of wrData.
//  Sits between the top-level go/ready handshake, the operand/result memories, and the datapath control pins.
// PARAMETERS
//  N_ITEMS   16  operands per run (>=1)
//  ADDR_W    4   read/write address width; must satisfy 2**ADDR_W >= N_ITEMS
//  SH_CNT    2   shEn cycles applied after each load (0 = no pre-shift)
//  TMO_W     8   width of the done-timeout counter; timeout = 2**TMO_W-1 cycles
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous, active-high reset
//  go        in   1       run request; sampled only in IDLE
//  expDone   in   1       done from exponential unit (level)
//  wrAck     in   1       result memory accepted write
//  ld        out  1       shift register load strobe
//  uiRegLd   out  1       ui register load strobe
//  shEn      out  1       shift register shift enable
//  expStart  out  1       exponential unit start pulse
//  rdAddr    out  ADDR_W  operand memory address (fracInput/ui valid same cycle, combinational read)
//  wrAddr    out  ADDR_W  result memory address
//  wrReq     out  1       write request for wrData
//  busy      out  1       high from leaving IDLE until return to IDLE
//  runDone   out  1       one-cycle pulse when the last write is acknowledged
//  err       out  1       sticky: expDone timeout occurred; cleared by rst or next accepted go
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; item counter=0; shift counter=0; timeout counter=0; err=0.
//  Outputs are Moore (decoded from state/counters), except rdAddr=wrAddr=item counter.
//  States:
//   IDLE   : busy=0. go=1 -> LOAD, clear item counter, clear err.
//   LOAD   : ld=1, uiRegLd=1 for exactly 1 cycle.
//            -> SHIFT if SH_CNT>0 (shift counter:=0), else -> START.
//   SHIFT  : shEn=1. Stays SH_CNT cycles, then -> START.
//   START  : expStart=1 for exactly 1 cycle; timeout counter:=0 -> WAIT.
//   WAIT   : counts cycles.
//            - expDone=1 -> WRITE. expDone is ignored in every state other than WAIT.
//            - If the counter reaches all-ones first: err:=1 and -> WRITE; the item is still written (result undefined).
//   WRITE  : wrReq held high until wrAck=1 (same-cycle ack allowed).
//            On ack:
//            - item counter == N_ITEMS-1 -> DONE.
//            - else item counter+1 -> LOAD.
//   DONE   : runDone=1 for 1 cycle -> IDLE.
//  Latency per item with SH_CNT=2, expDone after E cycles in WAIT, wrAck immediate: 1+2+1+E+1 cycles.
//  go held high across DONE starts a new run on the cycle after IDLE is re-entered.
//  go pulses while busy are ignored; they are not queued.
//  rst asserted mid-run (any state): next edge returns to IDLE with outputs low; no partial-run runDone.
//  The item counter never wraps within a run. With N_ITEMS=2**ADDR_W the last address is all-ones.
// TESTING
//  1. Reset: rst=1 for 2 cycles in WAIT mid-run -> all outputs 0, busy=0 next cycle, no runDone.
//  2. Single run, N_ITEMS=4, SH_CNT=2, expDone 5 cycles after expStart, wrAck immediate:
//     -> ld pulses at items 0..3; each followed by 2 shEn cycles; 4 expStart and 4 wrReq at wrAddr 0,1,2,3;
//     -> runDone one cycle after the 4th ack; busy low next cycle.
//  3. Write backpressure: wrAck delayed 3 cycles on item 1 -> wrReq held 4 cycles, wrAddr stable at 1;
//     no new ld until the ack.
//  4. Timeout: expDone never asserted for item 2 -> after 255 cycles err=1; item 2 is written; run completes.
//     err stays 1 until the next accepted go.
//  5. go/expDone noise: go pulsed during WAIT and expDone held high during LOAD/SHIFT -> no extra run;
//     no premature WRITE.
//  6. Back-to-back: go held high -> second run starts 1 cycle after IDLE is re-entered;
//     rdAddr restarts at 0; SH_CNT=0 build skips SHIFT (LOAD->START directly).

Source files
------------

// File: rtl/exp_seq_controller_if.sv
// Bus between the exponential sequence controller and its surroundings:
// top-level go/status, datapath control strobes and operand/result memory ports.
interface exp_seq_controller_if #(
  parameter int ADDR_W = 4
);
  // Handshakes: go is a request seen only while idle (not queued); wrReq is
  // valid and stays high with a stable wrAddr until the cycle wrAck is high
  // (wrAck may arrive in the first wrReq cycle); expStart is a one-cycle pulse
  // answered by the level expDone, which only counts while the controller waits.
  logic              go;
  logic              expDone;
  logic              wrAck;
  logic              ld;
  logic              uiRegLd;
  logic              shEn;
  logic              expStart;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] wrAddr;
  logic              wrReq;
  logic              busy;
  logic              runDone;
  logic              err;

  modport master (
    input  go, expDone, wrAck,
    output ld, uiRegLd, shEn, expStart, rdAddr, wrAddr, wrReq, busy, runDone, err
  );

  modport slave (
    output go, expDone, wrAck,
    input  ld, uiRegLd, shEn, expStart, rdAddr, wrAddr, wrReq, busy, runDone, err
  );
endinterface

// File: rtl/exp_seq_controller.sv
// Sequences N_ITEMS operands through load, pre-shift, exponential and write-back,
// with a done-timeout that flags err but still writes the item.
module exp_seq_controller #(
  parameter int N_ITEMS = 16,
  parameter int ADDR_W  = 4,
  parameter int SH_CNT  = 2,
  parameter int TMO_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  exp_seq_controller_if.master bus,
  output logic [2:0]           dbgState
);

  // IDLE is encoded as 0 so a debug probe reads 0 after reset.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } stateT;

  localparam int SHW = (SH_CNT > 1) ? $clog2(SH_CNT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ITEM = ADDR_W'(N_ITEMS - 1);
  localparam logic [SHW-1:0]    SH_LAST   = SHW'((SH_CNT > 0) ? SH_CNT - 1 : 0);
  // Trip on the cycle whose increment would make the counter all-ones.
  localparam logic [TMO_W-1:0]  TMO_TRIP  = TMO_W'((2 ** TMO_W) - 2);

  stateT             state;
  logic [ADDR_W-1:0] itemCnt;
  logic [SHW-1:0]    shCnt;
  logic [TMO_W-1:0]  tmoCnt;
  logic              ldR;
  logic              uiRegLdR;
  logic              shEnR;
  logic              expStartR;
  logic              wrReqR;
  logic              busyR;
  logic              runDoneR;
  logic              errR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      itemCnt   <= '0;
      shCnt     <= '0;
      tmoCnt    <= '0;
      ldR       <= 1'b0;
      uiRegLdR  <= 1'b0;
      shEnR     <= 1'b0;
      expStartR <= 1'b0;
      wrReqR    <= 1'b0;
      busyR     <= 1'b0;
      runDoneR  <= 1'b0;
      errR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            state    <= LOAD;
            ldR      <= 1'b1;
            uiRegLdR <= 1'b1;
            busyR    <= 1'b1;
            itemCnt  <= '0;
            errR     <= 1'b0;
          end
        end
        LOAD: begin
          ldR      <= 1'b0;
          uiRegLdR <= 1'b0;
          if (SH_CNT > 0) begin
            state <= SHIFT;
            shEnR <= 1'b1;
            shCnt <= '0;
          end else begin
            state     <= START;
            expStartR <= 1'b1;
          end
        end
        SHIFT: begin
          if (shCnt == SH_LAST) begin
            state     <= START;
            shEnR     <= 1'b0;
            expStartR <= 1'b1;
          end else begin
            shCnt <= shCnt + 1'b1;
          end
        end
        START: begin
          expStartR <= 1'b0;
          tmoCnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          tmoCnt <= tmoCnt + 1'b1;
          // A done arriving on the trip cycle wins over the timeout.
          if (bus.expDone) begin
            state  <= WRITE;
            wrReqR <= 1'b1;
          end else if (tmoCnt == TMO_TRIP) begin
            state  <= WRITE;
            wrReqR <= 1'b1;
            errR   <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.wrAck) begin
            wrReqR <= 1'b0;
            if (itemCnt == LAST_ITEM) begin
              state    <= DONE;
              runDoneR <= 1'b1;
            end else begin
              itemCnt  <= itemCnt + 1'b1;
              state    <= LOAD;
              ldR      <= 1'b1;
              uiRegLdR <= 1'b1;
            end
          end
        end
        DONE: begin
          runDoneR <= 1'b0;
          busyR    <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ldR       <= 1'b0;
          uiRegLdR  <= 1'b0;
          shEnR     <= 1'b0;
          expStartR <= 1'b0;
          wrReqR    <= 1'b0;
          busyR     <= 1'b0;
          runDoneR  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld       = ldR;
  assign bus.uiRegLd  = uiRegLdR;
  assign bus.shEn     = shEnR;
  assign bus.expStart = expStartR;
  assign bus.rdAddr   = itemCnt;
  assign bus.wrAddr   = itemCnt;
  assign bus.wrReq    = wrReqR;
  assign bus.busy     = busyR;
  assign bus.runDone  = runDoneR;
  assign bus.err      = errR;
  assign dbgState     = state;

endmodule
